// File: rtl/model_fnn_layer_engine.sv
// Fully-connected layer engine: buffers an input vector, then for each neuron
// loads a bias, streams one weight row through a single multiply-accumulate,
// saturates and activates the sum and emits it with its neuron index.
module model_fnn_layer_engine #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4,
    parameter int FRAC_SIZE    = 0,
    parameter int X            = 64,
    parameter int L            = 64
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    output logic                   READY,
    input  logic [1:0]             MODE_IN,
    input  logic [$clog2(X):0]     SIZE_X_IN,
    input  logic [$clog2(L):0]     SIZE_L_IN,
    input  logic [DATA_SIZE-1:0]   X_IN,
    input  logic                   X_IN_ENABLE,
    output logic                   X_REQ,
    input  logic [DATA_SIZE-1:0]   B_IN,
    input  logic                   B_IN_ENABLE,
    output logic                   B_REQ,
    input  logic [DATA_SIZE-1:0]   W_IN,
    input  logic                   W_IN_ENABLE,
    output logic                   W_REQ,
    output logic [DATA_SIZE-1:0]   H_OUT,
    output logic                   H_OUT_ENABLE,
    output logic [$clog2(L)-1:0]   H_INDEX,
    output logic                   DONE
);
    localparam int XA = $clog2(X);
    localparam int LA = $clog2(L);
    localparam int IW = XA + CONTROL_SIZE;
    localparam int NW = LA + CONTROL_SIZE;
    localparam int PW = 2 * DATA_SIZE;
    localparam int AW = PW + CONTROL_SIZE;

    localparam logic [XA:0] X_MAX = (XA + 1)'(X);
    localparam logic [LA:0] L_MAX = (LA + 1)'(L);

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};
    localparam logic signed [DATA_SIZE-1:0] UNIT_POS = {{(DATA_SIZE-1){1'b0}}, 1'b1} <<< FRAC_SIZE;
    localparam logic signed [DATA_SIZE-1:0] UNIT_NEG = -UNIT_POS;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_X = 3'd1,
        S_LOAD_B = 3'd2,
        S_MAC    = 3'd3,
        S_ACT    = 3'd4,
        S_EMIT   = 3'd5,
        S_FIN    = 3'd6
    } state_t;

    // A requested length of zero or beyond the buffer means "use the full buffer".
    function automatic logic [IW-1:0] clamp_x(input logic [XA:0] s);
        logic [XA:0] v;
        if ((s == {(XA+1){1'b0}}) || (s > X_MAX)) v = X_MAX;
        else                                      v = s;
        return IW'(v);
    endfunction

    function automatic logic [NW-1:0] clamp_l(input logic [LA:0] s);
        logic [LA:0] v;
        if ((s == {(LA+1){1'b0}}) || (s > L_MAX)) v = L_MAX;
        else                                      v = s;
        return NW'(v);
    endfunction

    // Saturate the wide accumulator into the data range, then apply the activation.
    function automatic logic [DATA_SIZE-1:0] activate(input logic signed [AW-1:0] acc,
                                                      input logic [1:0]            mode);
        logic signed [DATA_SIZE-1:0] sat;
        logic signed [DATA_SIZE-1:0] res;
        if (acc > SAT_MAX)      sat = SAT_MAX[DATA_SIZE-1:0];
        else if (acc < SAT_MIN) sat = SAT_MIN[DATA_SIZE-1:0];
        else                    sat = acc[DATA_SIZE-1:0];
        case (mode)
            2'd1: begin
                if (sat[DATA_SIZE-1]) res = {DATA_SIZE{1'b0}};
                else                  res = sat;
            end
            2'd2: begin
                if (sat > UNIT_POS)      res = UNIT_POS;
                else if (sat < UNIT_NEG) res = UNIT_NEG;
                else                     res = sat;
            end
            default: res = sat;
        endcase
        return res;
    endfunction

    state_t                      state_r, state_next_s;
    logic [DATA_SIZE-1:0]        x_mem_r [X];
    logic [IW-1:0]               size_x_r, x_idx_r;
    logic [NW-1:0]               size_l_r, l_idx_r;
    logic [1:0]                  mode_r;
    logic signed [AW-1:0]        acc_r;
    logic                        ready_r, x_req_r, b_req_r, w_req_r, h_en_r, done_r;
    logic [DATA_SIZE-1:0]        h_out_r;
    logic [LA-1:0]               h_index_r;

    logic                        x_fire_s, b_fire_s, w_fire_s, x_last_s, l_last_s;
    logic [DATA_SIZE-1:0]        x_sel_s;
    logic signed [PW-1:0]        w_ext_s, x_ext_s, prod_s, term_s;

    assign x_fire_s = x_req_r & X_IN_ENABLE;
    assign b_fire_s = b_req_r & B_IN_ENABLE;
    assign w_fire_s = w_req_r & W_IN_ENABLE;
    assign x_last_s = (x_idx_r == (size_x_r - IW'(1)));
    assign l_last_s = (l_idx_r == (size_l_r - NW'(1)));
    assign x_sel_s  = x_mem_r[x_idx_r[XA-1:0]];
    assign w_ext_s  = {{DATA_SIZE{W_IN[DATA_SIZE-1]}}, W_IN};
    assign x_ext_s  = {{DATA_SIZE{x_sel_s[DATA_SIZE-1]}}, x_sel_s};
    assign prod_s   = w_ext_s * x_ext_s;
    assign term_s   = prod_s >>> FRAC_SIZE;

    // Next-state decode; every transfer-driven state waits while its enable is low.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (START) state_next_s = S_LOAD_X;
                else       state_next_s = S_IDLE;
            end
            S_LOAD_X: begin
                if (x_fire_s && x_last_s) state_next_s = S_LOAD_B;
                else                      state_next_s = S_LOAD_X;
            end
            S_LOAD_B: begin
                if (b_fire_s) state_next_s = S_MAC;
                else          state_next_s = S_LOAD_B;
            end
            S_MAC: begin
                if (w_fire_s && x_last_s) state_next_s = S_ACT;
                else                      state_next_s = S_MAC;
            end
            S_ACT:  state_next_s = S_EMIT;
            S_EMIT: begin
                if (l_last_s) state_next_s = S_FIN;
                else          state_next_s = S_LOAD_B;
            end
            S_FIN:   state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register and handshake/status flags, registered from the next state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= S_IDLE;
            ready_r <= 1'b1;
            x_req_r <= 1'b0;
            b_req_r <= 1'b0;
            w_req_r <= 1'b0;
            h_en_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == S_IDLE);
            x_req_r <= (state_next_s == S_LOAD_X);
            b_req_r <= (state_next_s == S_LOAD_B);
            w_req_r <= (state_next_s == S_MAC);
            h_en_r  <= (state_next_s == S_EMIT);
            done_r  <= (state_next_s == S_FIN);
        end
    end

    // Input vector buffer; contents are only meaningful within the pass that wrote them.
    always_ff @(posedge CLK) begin
        if (x_fire_s) x_mem_r[x_idx_r[XA-1:0]] <= X_IN;
    end

    // Pass configuration, element/neuron counters, accumulator and result registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            size_x_r  <= {IW{1'b0}};
            size_l_r  <= {NW{1'b0}};
            mode_r    <= 2'd0;
            x_idx_r   <= {IW{1'b0}};
            l_idx_r   <= {NW{1'b0}};
            acc_r     <= {AW{1'b0}};
            h_out_r   <= {DATA_SIZE{1'b0}};
            h_index_r <= {LA{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (START) begin
                        size_x_r <= clamp_x(SIZE_X_IN);
                        size_l_r <= clamp_l(SIZE_L_IN);
                        mode_r   <= MODE_IN;
                        x_idx_r  <= {IW{1'b0}};
                        l_idx_r  <= {NW{1'b0}};
                    end
                end
                S_LOAD_X: begin
                    if (x_fire_s) begin
                        if (x_last_s) x_idx_r <= {IW{1'b0}};
                        else          x_idx_r <= x_idx_r + IW'(1);
                    end
                end
                S_LOAD_B: begin
                    if (b_fire_s) acc_r <= {{(AW-DATA_SIZE){B_IN[DATA_SIZE-1]}}, B_IN};
                end
                S_MAC: begin
                    if (w_fire_s) begin
                        acc_r <= acc_r + {{CONTROL_SIZE{term_s[PW-1]}}, term_s};
                        if (x_last_s) x_idx_r <= {IW{1'b0}};
                        else          x_idx_r <= x_idx_r + IW'(1);
                    end
                end
                S_ACT: begin
                    h_out_r   <= activate(acc_r, mode_r);
                    h_index_r <= l_idx_r[LA-1:0];
                end
                S_EMIT:  l_idx_r <= l_idx_r + NW'(1);
                S_FIN:   mode_r  <= mode_r;
                default: mode_r  <= mode_r;
            endcase
        end
    end

    assign READY        = ready_r;
    assign X_REQ        = x_req_r;
    assign B_REQ        = b_req_r;
    assign W_REQ        = w_req_r;
    assign H_OUT        = h_out_r;
    assign H_OUT_ENABLE = h_en_r;
    assign H_INDEX      = h_index_r;
    assign DONE         = done_r;

endmodule
